regfile_access_arbiter: RTL and testbench

Shares the 16x16-bit register file ports between the core pipeline and a debug engine. The register file has two combinational read ports and one clocked write port.
- The core always has priority on read port 1 and on the write port.
- The debug engine performs bulk dump (read r0..r15 out over a valid/ready stream) or bulk load (write r0..r15 from a valid/ready stream).
- A starvation counter forces a one-cycle core stall so the engine is guaranteed to make progress.

---
 rtl/regfile_access_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_access_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arbiter.sv
// Shares register-file read port 1 and the write port between the core pipeline
// and a debug engine that bulk-dumps or bulk-loads r0..r(NREG-1) over valid/ready streams.
module regfile_access_arbiter #(
    parameter int NREG         = 16,
    parameter int AW           = 4,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_rd_en,
    input  logic [AW-1:0] core_src1,
    input  logic [AW-1:0] core_src2,
    input  logic          core_wr_en,
    input  logic [AW-1:0] core_dst,
    input  logic [DW-1:0] core_wr_data,
    output logic          core_stall,
    output logic [AW-1:0] rf_src1,
    output logic [AW-1:0] rf_src2,
    input  logic [DW-1:0] rf_rd_data1,
    output logic [AW-1:0] rf_dst,
    output logic          rf_wr_en,
    output logic [DW-1:0] rf_wr_data,
    input  logic          dbg_cmd_valid,
    output logic          dbg_cmd_ready,
    input  logic          dbg_cmd_op,
    input  logic [DW-1:0] dbg_load_data,
    input  logic          dbg_load_valid,
    output logic          dbg_load_ready,
    output logic [DW-1:0] dbg_dump_data,
    output logic [AW-1:0] dbg_dump_idx,
    output logic          dbg_dump_valid,
    input  logic          dbg_dump_ready,
    output logic          dbg_busy,
    output logic          dbg_done
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DUMP_RD, S_DUMP_HOLD, S_LOAD} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_wait;
    logic [DW-1:0] r_dump_data;
    logic [AW-1:0] r_dump_idx;
    logic          r_dump_valid;
    logic          r_done;

    logic w_pending, w_stall, w_rd_gnt, w_wr_gnt, w_last, w_dump_hs;

    assign w_pending = (r_state == S_DUMP_RD) || ((r_state == S_LOAD) && dbg_load_valid);
    assign w_stall   = w_pending && (r_wait == CW'(STARVE_LIMIT));
    // Grants only ever take a port from the core when it is idle or being stalled.
    assign w_rd_gnt  = (r_state == S_DUMP_RD) && (!core_rd_en || w_stall);
    assign w_wr_gnt  = (r_state == S_LOAD) && dbg_load_valid && (!core_wr_en || w_stall);
    assign w_last    = (r_idx == AW'(NREG - 1));
    assign w_dump_hs = (r_state == S_DUMP_HOLD) && r_dump_valid && dbg_dump_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (dbg_cmd_valid) w_next = dbg_cmd_op ? S_LOAD : S_DUMP_RD;
            S_DUMP_RD:   if (w_rd_gnt) w_next = S_DUMP_HOLD;
            S_DUMP_HOLD: if (w_dump_hs) w_next = w_last ? S_IDLE : S_DUMP_RD;
            S_LOAD:      if (w_wr_gnt && w_last) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (r_state == S_IDLE && dbg_cmd_valid) begin
            r_idx <= '0;
        end else if ((w_dump_hs || w_wr_gnt) && !w_last) begin
            r_idx <= r_idx + AW'(1);
        end
    end

    // Counts consecutive denied pending cycles; saturation is what raises core_stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (!w_pending || w_rd_gnt || w_wr_gnt) begin
            r_wait <= '0;
        end else if (r_wait != CW'(STARVE_LIMIT)) begin
            r_wait <= r_wait + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dump_data  <= '0;
            r_dump_idx   <= '0;
            r_dump_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_rd_gnt) begin
                r_dump_data  <= rf_rd_data1;
                r_dump_idx   <= r_idx;
                r_dump_valid <= 1'b1;
            end else if (w_dump_hs) begin
                r_dump_valid <= 1'b0;
            end
            r_done <= (w_dump_hs || w_wr_gnt) && w_last;
        end
    end

    assign core_stall     = w_stall;
    assign rf_src1        = w_rd_gnt ? r_idx : core_src1;
    assign rf_src2        = core_src2;
    assign rf_dst         = w_wr_gnt ? r_idx : core_dst;
    assign rf_wr_data     = w_wr_gnt ? dbg_load_data : core_wr_data;
    assign rf_wr_en       = w_wr_gnt || (core_wr_en && !w_stall);
    assign dbg_load_ready = w_wr_gnt;
    assign dbg_cmd_ready  = (r_state == S_IDLE);
    assign dbg_busy       = (r_state != S_IDLE);
    assign dbg_dump_data  = r_dump_data;
    assign dbg_dump_idx   = r_dump_idx;
    assign dbg_dump_valid = r_dump_valid;
    assign dbg_done       = r_done;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Scoreboard bench: a register-file model plus an expected-contents array; dump beats
// and engine writes are queued at command issue and checked by a negedge monitor.
module tb_regfile_access_arbiter;
    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_rd_en, core_wr_en, core_stall;
    logic [AW-1:0] core_src1, core_src2, core_dst;
    logic [DW-1:0] core_wr_data;
    logic [AW-1:0] rf_src1, rf_src2, rf_dst;
    logic [DW-1:0] rf_rd_data1, rf_wr_data;
    logic          rf_wr_en;
    logic          dbg_cmd_valid, dbg_cmd_ready, dbg_cmd_op;
    logic [DW-1:0] dbg_load_data, dbg_dump_data;
    logic          dbg_load_valid, dbg_load_ready;
    logic [AW-1:0] dbg_dump_idx;
    logic          dbg_dump_valid, dbg_dump_ready, dbg_busy, dbg_done;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         dq[$];
    beat_t         lq[$];
    logic [DW-1:0] rf     [NREG];
    logic [DW-1:0] exp_rf [NREG];
    int            checks = 0;
    int            errors = 0;

    regfile_access_arbiter #(.NREG(NREG), .AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .core_rd_en(core_rd_en), .core_src1(core_src1), .core_src2(core_src2),
        .core_wr_en(core_wr_en), .core_dst(core_dst), .core_wr_data(core_wr_data),
        .core_stall(core_stall),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_rd_data1(rf_rd_data1),
        .rf_dst(rf_dst), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
        .dbg_cmd_valid(dbg_cmd_valid), .dbg_cmd_ready(dbg_cmd_ready), .dbg_cmd_op(dbg_cmd_op),
        .dbg_load_data(dbg_load_data), .dbg_load_valid(dbg_load_valid),
        .dbg_load_ready(dbg_load_ready),
        .dbg_dump_data(dbg_dump_data), .dbg_dump_idx(dbg_dump_idx),
        .dbg_dump_valid(dbg_dump_valid), .dbg_dump_ready(dbg_dump_ready),
        .dbg_busy(dbg_busy), .dbg_done(dbg_done)
    );

    always #5 clk = ~clk;

    // Register file: combinational read port 1, clocked write port.
    always @(posedge clk) if (rf_wr_en) rf[rf_dst] <= rf_wr_data;
    assign rf_rd_data1 = rf[rf_src1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            chk("src2_pass", 32'(rf_src2), 32'(core_src2));
            if (core_rd_en && !core_stall) chk("core_rd_port", 32'(rf_src1), 32'(core_src1));
            if (dbg_dump_valid && dbg_dump_ready) begin
                if (dq.size() == 0) chk("dump_unexpected_beat", 1, 0);
                else begin
                    e = dq.pop_front();
                    chk("dump_beat", {12'd0, dbg_dump_idx, dbg_dump_data}, {12'd0, e.idx, e.data});
                end
            end
            if (dbg_load_ready) begin
                if (lq.size() == 0) chk("load_unexpected_write", 1, 0);
                else begin
                    e = lq.pop_front();
                    chk("load_write", {11'd0, rf_wr_en, rf_dst, rf_wr_data}, {11'd0, 1'b1, e.idx, e.data});
                    exp_rf[e.idx] = e.data;
                end
            end else if (core_wr_en && !core_stall) begin
                chk("core_write", {11'd0, rf_wr_en, rf_dst, rf_wr_data}, {11'd0, 1'b1, core_dst, core_wr_data});
                exp_rf[core_dst] = core_wr_data;
            end else if (core_stall) begin
                chk("stall_wr_suppressed", 32'(rf_wr_en), 0);
            end
        end
    end

    task automatic reset_checks();
        chk("rst_busy", 32'(dbg_busy), 0);
        chk("rst_cmd_ready", 32'(dbg_cmd_ready), 1);
        chk("rst_dump_valid", 32'(dbg_dump_valid), 0);
        chk("rst_dump_data", 32'(dbg_dump_data), 0);
        chk("rst_dump_idx", 32'(dbg_dump_idx), 0);
        chk("rst_done", 32'(dbg_done), 0);
        chk("rst_stall", 32'(core_stall), 0);
    endtask

    // mode: 0 core idle, 1 core_rd_en alternating, 2 random core reads and dump_ready
    task automatic run_dump(input int mode, input bit stall3, input bit pulse);
        int            hold = 0;
        bit            done = 0;
        bit            holding;
        logic [DW-1:0] d3;
        for (int i = 0; i < NREG; i++) dq.push_back('{idx: AW'(i), data: exp_rf[i]});
        d3 = exp_rf[3];
        dbg_cmd_valid = 1; dbg_cmd_op = 0;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(dbg_cmd_ready), 1);
        step();
        dbg_cmd_valid = 0;
        for (int cyc = 1; cyc < 1000 && !done; cyc++) begin
            core_src1 = AW'($urandom);
            core_src2 = AW'($urandom);
            case (mode)
                0:       core_rd_en = 0;
                1:       core_rd_en = cyc[0];
                default: core_rd_en = ($urandom_range(0, 7) != 0);
            endcase
            dbg_dump_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            holding = 0;
            if (stall3 && dbg_dump_valid && dbg_dump_idx == 3 && hold < 5) begin
                dbg_dump_ready = 0; hold++; holding = 1;
            end
            dbg_cmd_valid  = pulse && cyc == 5;
            dbg_cmd_op     = 1;
            dbg_load_valid = pulse && cyc == 5;
            @(negedge clk);
            if (holding) begin
                chk("hold_valid", 32'(dbg_dump_valid), 1);
                chk("hold_idx", 32'(dbg_dump_idx), 3);
                chk("hold_data", 32'(dbg_dump_data), 32'(d3));
            end
            if (pulse && cyc == 5) chk("cmd_ready_busy", 32'(dbg_cmd_ready), 0);
            if (dbg_done) begin
                done = 1;
                if (mode == 0 && !stall3) chk("dump_latency", cyc, 33);
            end else step();
        end
        dbg_cmd_valid = 0; dbg_load_valid = 0;
        chk("dump_finished", 32'(done), 1);
        chk("dump_busy_clear", 32'(dbg_busy), 0);
        chk("dump_all_beats", dq.size(), 0);
        dq.delete();
        step();
        core_rd_en = 0;
    endtask

    // mode: 0 core idle, 1 core_wr_en held high, 2 random core writes and load_valid
    task automatic run_load(input int mode, input logic [DW-1:0] base, input int abort_n);
        logic [DW-1:0] v[NREG];
        int            beat = 0;
        bit            held = 0;
        bit            done = 0;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (mode == 0) ? DW'(base + DW'(i)) : DW'($urandom);
            lq.push_back('{idx: AW'(i), data: v[i]});
        end
        dbg_cmd_valid = 1; dbg_cmd_op = 1;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(dbg_cmd_ready), 1);
        step();
        dbg_cmd_valid = 0;
        for (int cyc = 1; cyc < 1000 && !done; cyc++) begin
            dbg_load_valid = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (beat < NREG) dbg_load_data = v[beat];
            if (!held) begin
                core_wr_en   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                core_dst     = AW'($urandom);
                core_wr_data = DW'($urandom);
            end
            @(negedge clk);
            if (mode == 1 && beat < NREG) begin
                chk("load_grant_slot", 32'(dbg_load_ready), 32'(cyc % 9 == 0));
                chk("starve_stall", 32'(core_stall), 32'(cyc % 9 == 0));
            end
            held = core_wr_en && core_stall;
            if (dbg_load_ready) beat++;
            if (dbg_done) done = 1;
            else if (abort_n > 0 && beat == abort_n) begin
                step();
                rst = 1; dbg_load_valid = 0; core_wr_en = 0;
                #1;
                reset_checks();
                step();
                rst = 0;
                lq.delete();
                return;
            end else step();
        end
        chk("load_finished", 32'(done), 1);
        chk("load_busy_clear", 32'(dbg_busy), 0);
        chk("load_all_writes", lq.size(), 0);
        lq.delete();
        step();
        core_wr_en = 0; dbg_load_valid = 0;
    endtask

    initial begin
        rst = 1;
        core_rd_en = 0; core_wr_en = 0; core_src1 = '0; core_src2 = '0;
        core_dst = '0; core_wr_data = '0;
        dbg_cmd_valid = 0; dbg_cmd_op = 0; dbg_load_data = '0; dbg_load_valid = 0;
        dbg_dump_ready = 0;
        #12;
        reset_checks();
        step();
        rst = 0;
        for (int i = 0; i < NREG; i++) begin
            core_wr_en = 1; core_dst = AW'(i); core_wr_data = DW'(16'h1000 + i);
            step();
        end
        core_wr_en = 0;
        run_dump(0, 0, 0);
        run_load(0, 16'hA000, 0);
        run_dump(0, 0, 1);
        run_load(1, 16'h0000, 0);
        run_dump(1, 0, 0);
        run_dump(0, 1, 0);
        run_load(0, 16'hB000, 8);
        run_dump(0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            run_load(2, 16'h0000, 0);
            run_dump(2, 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
